// File: rtl/radix_stage_sched_pkg.sv
// ---------------------------------------------------------------------------
// radix_stage_sched_pkg
// Shared definitions for the radix-2 SDF stage scheduler:
//   - FSM state encoding (IDLE / FILL / DRAIN)
//   - output-mux select encodings
//   - output tag layout carried down the alignment pipe
//   - rule deriving the total alignment latency from the read and
//     multiplier latencies
// ---------------------------------------------------------------------------
package radix_stage_sched_pkg;

  localparam logic [1:0] IDLE_ENC  = 2'd0;
  localparam logic [1:0] FILL_ENC  = 2'd1;
  localparam logic [1:0] DRAIN_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE_ENC,
    ST_FILL  = FILL_ENC,
    ST_DRAIN = DRAIN_ENC
  } state_e;

  // Output mux select: delayed y1 path or twiddled y2 from the multiplier.
  localparam logic SEL_Y1  = 1'b0;
  localparam logic SEL_MUL = 1'b1;

  typedef struct packed {
    logic valid;
    logic sel;
  } tag_t;

  // The y1 delay line in the datapath must match this value so both
  // streams reach the output mux aligned.
  function automatic int path_lat(input int rd_lat, input int mul_lat);
    return rd_lat + mul_lat;
  endfunction

endpackage

// File: rtl/radix_stage_sched_if.sv
// ---------------------------------------------------------------------------
// radix_stage_sched_if
// Bundles the scheduler's control signals.
//   master : scheduler side (drives buffer/twiddle/output controls)
//   slave  : datapath/environment side (drives en, bf_valid, mul_valid)
// Handshake: a butterfly pair is transferred on a cycle where both
// bf_valid and in_ready are high; bf_valid while in_ready is low is an
// overrun (sample dropped, err set). No other signal is back-pressured.
// dbg_state exposes the FSM state for observation only.
// ---------------------------------------------------------------------------
interface radix_stage_sched_if #(
  parameter int ADDR_W = 12
);
  import radix_stage_sched_pkg::*;

  logic              en;
  logic              bf_valid;
  logic              in_ready;
  logic              buf_wr_en;
  logic [ADDR_W-1:0] buf_wr_addr;
  logic              buf_rd_en;
  logic [ADDR_W-1:0] buf_rd_addr;
  logic              tf_en;
  logic [ADDR_W-1:0] tf_addr;
  logic              mul_valid;
  logic              out_valid;
  logic              out_sel;
  logic              frame_done;
  logic              err;
  state_e            dbg_state;

  modport master (
    input  en, bf_valid, mul_valid,
    output in_ready, buf_wr_en, buf_wr_addr, buf_rd_en, buf_rd_addr,
           tf_en, tf_addr, out_valid, out_sel, frame_done, err, dbg_state
  );

  modport slave (
    output en, bf_valid, mul_valid,
    input  in_ready, buf_wr_en, buf_wr_addr, buf_rd_en, buf_rd_addr,
           tf_en, tf_addr, out_valid, out_sel, frame_done, err, dbg_state
  );

endinterface

// File: rtl/radix_stage_sched_tag_delay_line.sv
// ---------------------------------------------------------------------------
// radix_stage_sched_tag_delay_line
// Fixed-depth shift register for small tags. dout_o is din_i delayed by
// DEPTH cycles. Synchronous reset clears every stage.
//   clk, rst : clock, synchronous active-high reset
//   din_i    : tag entering the line
//   dout_o   : tag leaving the line (last stage)
// DEPTH must be at least 1.
// ---------------------------------------------------------------------------
module radix_stage_sched_tag_delay_line #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dout_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/radix_stage_sched.sv
// ---------------------------------------------------------------------------
// radix_stage_sched
// Sequencing controller for one radix-2 SDF FFT stage. A frame fills the
// y2 buffer with HALF_LEN butterfly outputs (gaps allowed), then drains it
// in HALF_LEN back-to-back reads with twiddle addressing. Tags for the y1
// samples and the reads travel down an alignment pipe so the output mux
// sees the y1 stream followed by the twiddled y2 stream without collision.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : master modport of radix_stage_sched_if
//               (en, bf_valid, mul_valid in; buffer/twiddle strobes and
//                addresses, in_ready, out_valid, out_sel, frame_done,
//                sticky err and dbg_state out)
// ---------------------------------------------------------------------------
module radix_stage_sched
  import radix_stage_sched_pkg::*;
#(
  parameter int HALF_LEN       = 4096,
  parameter int ADDR_W         = 12,
  parameter int TF_STRIDE_LOG2 = 0,
  parameter int RD_LAT         = 1,
  parameter int MUL_LAT        = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  radix_stage_sched_if.master  bus
);

  localparam int PATH_LAT = path_lat(RD_LAT, MUL_LAT);
  // One extra bit so HALF_LEN == 2**ADDR_W does not alias to zero.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_LEN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] out_cnt_q;
  logic             out_valid_q, out_sel_q, frame_done_q, err_q;

  logic             in_ready, wr_en, rd_en;
  logic [ADDR_W-1:0] rd_idx;
  tag_t             tag_in, tag_tail;
  logic             mul_in_vld, mul_exp;

  // -------------------------------------------------------------------------
  // FSM next state and combinational strobes
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    in_ready = 1'b0;

    case (state_q)
      ST_IDLE: in_ready = bus.en;
      ST_FILL: in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
    // Outputs are held low while reset is asserted.
    if (rst) in_ready = 1'b0;

    wr_en = in_ready & bus.bf_valid;
    rd_en = !rst && (state_q == ST_DRAIN);

    // In IDLE wr_cnt_q is always 0, so IDLE and FILL share the accept path.
    if (wr_en) begin
      if (wr_cnt_q == LAST) begin
        wr_cnt_d = '0;
        state_d  = ST_DRAIN;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
        state_d  = ST_FILL;
      end
    end

    if (rd_en) begin
      if (rd_cnt_q == LAST) begin
        rd_cnt_d = '0;
        state_d  = bus.en ? ST_FILL : ST_IDLE;
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign rd_idx          = rd_cnt_q[ADDR_W-1:0];
  assign bus.in_ready    = in_ready;
  assign bus.buf_wr_en   = wr_en;
  assign bus.buf_wr_addr = wr_en ? wr_cnt_q[ADDR_W-1:0] : '0;
  assign bus.buf_rd_en   = rd_en;
  assign bus.buf_rd_addr = rd_en ? rd_idx : '0;
  assign bus.tf_en       = rd_en;
  assign bus.tf_addr     = rd_en ? ADDR_W'(rd_idx << TF_STRIDE_LOG2) : '0;
  assign bus.dbg_state   = state_q;

  // -------------------------------------------------------------------------
  // Output tag alignment pipe. Writes and reads never share a cycle, so one
  // tag per cycle is enough.
  // -------------------------------------------------------------------------
  always_comb begin
    tag_in = '0;
    if (wr_en) begin
      tag_in.valid = 1'b1;
      tag_in.sel   = SEL_Y1;
    end else if (rd_en) begin
      tag_in.valid = 1'b1;
      tag_in.sel   = SEL_MUL;
    end
  end

  radix_stage_sched_tag_delay_line #(
    .DEPTH (PATH_LAT),
    .WIDTH ($bits(tag_t))
  ) u_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .din_i  (tag_in),
    .dout_o (tag_tail)
  );

  // -------------------------------------------------------------------------
  // Misalignment check: the read strobe reaches the multiplier input RD_LAT
  // cycles later, and mul_valid must follow that by exactly MUL_LAT cycles.
  // -------------------------------------------------------------------------
  if (RD_LAT > 0) begin : g_rd_pipe
    radix_stage_sched_tag_delay_line #(
      .DEPTH (RD_LAT),
      .WIDTH (1)
    ) u_rd_pipe (
      .clk    (clk),
      .rst    (rst),
      .din_i  (rd_en),
      .dout_o (mul_in_vld)
    );
  end else begin : g_rd_direct
    assign mul_in_vld = rd_en;
  end

  radix_stage_sched_tag_delay_line #(
    .DEPTH (MUL_LAT),
    .WIDTH (1)
  ) u_chk_pipe (
    .clk    (clk),
    .rst    (rst),
    .din_i  (mul_in_vld),
    .dout_o (mul_exp)
  );

  // -------------------------------------------------------------------------
  // Registered output strobes, frame counter and sticky error
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_sel_q    <= 1'b0;
      frame_done_q <= 1'b0;
      out_cnt_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      out_valid_q  <= tag_tail.valid;
      out_sel_q    <= tag_tail.valid & (tag_tail.sel == SEL_MUL);
      frame_done_q <= 1'b0;
      if (tag_tail.valid && (tag_tail.sel == SEL_MUL)) begin
        if (out_cnt_q == LAST) begin
          out_cnt_q    <= '0;
          frame_done_q <= 1'b1;
        end else begin
          out_cnt_q <= out_cnt_q + 1'b1;
        end
      end
      if ((bus.bf_valid && !in_ready) || (bus.mul_valid != mul_exp)) err_q <= 1'b1;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_sel    = out_sel_q;
  assign bus.frame_done = frame_done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_radix_stage_sched.sv
// ---------------------------------------------------------------------------
// tb_radix_stage_sched
// Two schedulers (twiddle stride 0 and 1) share the same stimulus. A
// frame-level reference model predicts every strobe, address and output
// event; expected output events wait in exp_q keyed by the cycle they are due.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_radix_stage_sched;
  import radix_stage_sched_pkg::*;

  localparam int HALF_LEN = 8;
  localparam int ADDR_W   = 3;
  localparam int RD_LAT   = 1;
  localparam int MUL_LAT  = 3;
  localparam int LAT      = RD_LAT + MUL_LAT;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  radix_stage_sched_if #(.ADDR_W(ADDR_W)) bus0 ();
  radix_stage_sched_if #(.ADDR_W(ADDR_W)) bus1 ();

  radix_stage_sched #(
    .HALF_LEN(HALF_LEN), .ADDR_W(ADDR_W), .TF_STRIDE_LOG2(0),
    .RD_LAT(RD_LAT), .MUL_LAT(MUL_LAT)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  radix_stage_sched #(
    .HALF_LEN(HALF_LEN), .ADDR_W(ADDR_W), .TF_STRIDE_LOG2(1),
    .RD_LAT(RD_LAT), .MUL_LAT(MUL_LAT)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // ---------------- bookkeeping ----------------
  int n_asserts = 0;
  int n_fail    = 0;
  int t         = 0;

  // ---------------- reference model state ----------------
  bit m_open;        // a frame is collecting samples (in_ready regardless of en)
  int m_acc;         // samples accepted in the current fill
  int m_drain_left;  // read cycles still to issue
  int m_drain_idx;
  bit m_err;
  int mul_extra;     // extra multiplier delay used to provoke misalignment
  logic [33:0] exp_q[$];  // {due cycle, sel, frame_done}
  int chk_q[$];           // cycles where mul_valid is due
  int mul_q[$];           // cycles where the multiplier model raises mul_valid

  // expected values for the current cycle
  bit x_ready, x_wr, x_rd, x_ov, x_sel, x_fd, x_mul;
  int x_wr_addr, x_rd_addr;

  // observations
  int fd_count = 0;
  int fd_cyc   = -1;
  int wr_count = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input string who, input logic ir, input logic we,
                         input logic [ADDR_W-1:0] wa, input logic re,
                         input logic [ADDR_W-1:0] ra, input logic te,
                         input logic [ADDR_W-1:0] ta, input logic ov,
                         input logic os, input logic fd, input logic er,
                         input int exp_ta);
    chk({who, ".in_ready"},    ir, x_ready);
    chk({who, ".buf_wr_en"},   we, x_wr);
    chk({who, ".buf_rd_en"},   re, x_rd);
    chk({who, ".tf_en"},       te, x_rd);
    if (x_wr) chk({who, ".buf_wr_addr"}, wa, x_wr_addr);
    if (x_rd) chk({who, ".buf_rd_addr"}, ra, x_rd_addr);
    if (x_rd) chk({who, ".tf_addr"},     ta, exp_ta);
    chk({who, ".out_valid"},   ov, x_ov);
    chk({who, ".out_sel"},     os, x_sel);
    chk({who, ".frame_done"},  fd, x_fd);
    chk({who, ".err"},         er, m_err);
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input bit r, input bit e, input bit b);
    logic [33:0] ent;
    bit chk_hit;
    @(negedge clk);
    t++;
    x_mul = 1'b0;
    if (mul_q.size() > 0 && mul_q[0] == t) begin
      x_mul = 1'b1;
      void'(mul_q.pop_front());
    end
    rst = r;
    bus0.en = e;  bus0.bf_valid = b;  bus0.mul_valid = x_mul;
    bus1.en = e;  bus1.bf_valid = b;  bus1.mul_valid = x_mul;
    #1;

    // expectations for this cycle
    x_ready   = !r && (m_drain_left == 0) && (m_open || e);
    x_wr      = x_ready && b;
    x_wr_addr = m_acc;
    x_rd      = !r && (m_drain_left > 0);
    x_rd_addr = m_drain_idx;
    x_ov = 0; x_sel = 0; x_fd = 0;
    if (exp_q.size() > 0 && exp_q[0][33:2] == 32'(t)) begin
      ent   = exp_q.pop_front();
      x_ov  = 1'b1;
      x_sel = ent[1];
      x_fd  = ent[0];
    end

    chk_dut("d0", bus0.in_ready, bus0.buf_wr_en, bus0.buf_wr_addr, bus0.buf_rd_en,
            bus0.buf_rd_addr, bus0.tf_en, bus0.tf_addr, bus0.out_valid, bus0.out_sel,
            bus0.frame_done, bus0.err, x_rd_addr % (1 << ADDR_W));
    chk_dut("d1", bus1.in_ready, bus1.buf_wr_en, bus1.buf_wr_addr, bus1.buf_rd_en,
            bus1.buf_rd_addr, bus1.tf_en, bus1.tf_addr, bus1.out_valid, bus1.out_sel,
            bus1.frame_done, bus1.err, (x_rd_addr * 2) % (1 << ADDR_W));

    if (bus0.frame_done === 1'b1) begin fd_count++; fd_cyc = t; end
    if (bus0.buf_wr_en === 1'b1) wr_count++;

    // model update for the coming edge
    chk_hit = (chk_q.size() > 0 && chk_q[0] == t);
    if (chk_hit) void'(chk_q.pop_front());
    if (r) begin
      m_open = 0; m_acc = 0; m_drain_left = 0; m_drain_idx = 0; m_err = 0;
      exp_q.delete(); chk_q.delete(); mul_q.delete();
    end else begin
      if (b && !x_ready) m_err = 1;
      if (x_mul != chk_hit) m_err = 1;
      if (x_wr) begin
        exp_q.push_back({32'(t + LAT + 1), SEL_Y1, 1'b0});
        m_acc++;
        m_open = 1;
        if (m_acc == HALF_LEN) begin
          m_acc = 0; m_open = 0; m_drain_left = HALF_LEN; m_drain_idx = 0;
        end
      end else if (x_rd) begin
        exp_q.push_back({32'(t + LAT + 1), SEL_MUL, (m_drain_left == 1)});
        chk_q.push_back(t + LAT);
        mul_q.push_back(t + LAT + mul_extra);
        m_drain_idx++;
        m_drain_left--;
        if (m_drain_left == 0) m_open = e;
      end
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int s, fd_before, wr_before;
    rst = 1'b1;
    bus0.en = 0; bus0.bf_valid = 0; bus0.mul_valid = 0;
    bus1.en = 0; bus1.bf_valid = 0; bus1.mul_valid = 0;
    m_open = 0; m_acc = 0; m_drain_left = 0; m_drain_idx = 0; m_err = 0;
    mul_extra = 0;
    @(posedge clk);

    // reset held with bf_valid high
    step(1, 1, 1);
    step(1, 1, 1);
    chk("reset_state_d0", bus0.dbg_state, ST_IDLE);
    chk("reset_state_d1", bus1.dbg_state, ST_IDLE);
    chk("reset_no_writes", wr_count, 0);
    step(0, 0, 0);

    // continuous frame
    s = t + 1;
    for (int i = 0; i < HALF_LEN; i++) step(0, 1, 1);
    for (int i = 0; i < 14; i++) step(0, 1, 0);
    chk("cont_frame_done_cycle", fd_cyc, s + 20);
    chk("cont_frame_done_count", fd_count, 1);

    // gappy fill, en drops during drain so the stage returns to IDLE
    wr_before = wr_count;
    for (int i = 0; i < 2 * HALF_LEN; i++) step(0, 1, (i % 2) == 0);
    for (int i = 0; i < 14; i++) step(0, 0, 0);
    chk("gappy_writes", wr_count - wr_before, HALF_LEN);
    chk("gappy_frame_done_count", fd_count, 2);
    chk("gappy_idle_state", bus0.dbg_state, ST_IDLE);

    // overrun: bf_valid held through drain
    wr_before = wr_count;
    for (int i = 0; i < HALF_LEN; i++) step(0, 1, 1);
    for (int i = 0; i < HALF_LEN; i++) step(0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0);
    chk("overrun_writes", wr_count - wr_before, HALF_LEN);
    chk("overrun_err_sticky", bus0.err, 1);
    step(1, 0, 0);
    step(0, 0, 0);

    // misalignment: multiplier answers one cycle late
    mul_extra = 1;
    for (int i = 0; i < HALF_LEN; i++) step(0, 1, 1);
    for (int i = 0; i < 14; i++) step(0, 0, 0);
    chk("misalign_err", bus0.err, 1);
    mul_extra = 0;
    step(1, 0, 0);

    // reset in the 4th drain cycle: no frame_done from the aborted frame
    fd_before = fd_count;
    for (int i = 0; i < HALF_LEN; i++) step(0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    chk("midreset_no_frame_done", fd_count, fd_before);

    // the following frame behaves exactly like the continuous one
    s = t + 1;
    for (int i = 0; i < HALF_LEN; i++) step(0, 1, 1);
    for (int i = 0; i < 14; i++) step(0, 0, 0);
    chk("post_reset_frame_done_cycle", fd_cyc, s + 20);
    chk("post_reset_err_clear", bus0.err, 0);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end
    step(1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
